// File: rtl/fp_mac_seq_driver.sv
// Dot-product sequencer for an AXI-Stream FP MAC core (a*b+c).
// Each issue feeds the previous MAC result back in as c; operands come from a host-loaded buffer.
module fp_mac_seq_driver #(
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_a,
   input  logic [31:0]       wr_b,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   output logic              m_axis_a_tvalid,
   input  logic              m_axis_a_tready,
   output logic [31:0]       m_axis_a_tdata,
   output logic              m_axis_b_tvalid,
   input  logic              m_axis_b_tready,
   output logic [31:0]       m_axis_b_tdata,
   output logic              m_axis_c_tvalid,
   input  logic              m_axis_c_tready,
   output logic [31:0]       m_axis_c_tdata,
   input  logic              s_axis_result_tvalid,
   output logic              s_axis_result_tready,
   input  logic [31:0]       s_axis_result_tdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       acc_out,
   output logic [15:0]       cycles
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int TW    = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      FIN
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [31:0]       r_buf_a [DEPTH];
   logic [31:0]       r_buf_b [DEPTH];

   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W:0]   r_len;
   logic [31:0]       r_acc;
   logic [31:0]       r_acc_out;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_tmo;
   logic [15:0]       r_cycles;
   logic [TW-1:0]     r_tmo_cnt;
   logic              r_sent_a;
   logic              r_sent_b;
   logic              r_sent_c;

   logic              w_hs_a;
   logic              w_hs_b;
   logic              w_hs_c;
   logic              w_issue_done;
   logic              w_res_hs;
   logic              w_last;
   logic              w_tmo_hit;
   logic              w_start_ok;
   logic              w_wr_ok;

   assign w_start_ok   = start && (r_state == IDLE);
   assign w_wr_ok      = wr_en && !r_busy;
   assign w_hs_a       = m_axis_a_tvalid && m_axis_a_tready;
   assign w_hs_b       = m_axis_b_tvalid && m_axis_b_tready;
   assign w_hs_c       = m_axis_c_tvalid && m_axis_c_tready;
   // Channels may complete in different cycles; count this cycle's handshakes as done too.
   assign w_issue_done = (r_sent_a || w_hs_a) && (r_sent_b || w_hs_b) && (r_sent_c || w_hs_c);
   assign w_res_hs     = s_axis_result_tvalid && s_axis_result_tready;
   assign w_last       = ({1'b0, r_idx} == (r_len - (ADDR_W+1)'(1)));
   assign w_tmo_hit    = (r_tmo_cnt == TW'(TIMEOUT - 1));

   assign busy    = r_busy;
   assign done    = r_done;
   assign err     = r_err;
   assign acc_out = r_acc_out;
   assign cycles  = r_cycles;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_start_ok) begin
               w_next = (len == '0) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            if (w_issue_done) begin
               w_next = WAIT;
            end
         end
         WAIT: begin
            if (w_res_hs) begin
               w_next = w_last ? FIN : ISSUE;
            end else if (w_tmo_hit) begin
               w_next = FIN;
            end
         end
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      m_axis_a_tvalid      = (r_state == ISSUE) && !r_sent_a;
      m_axis_b_tvalid      = (r_state == ISSUE) && !r_sent_b;
      m_axis_c_tvalid      = (r_state == ISSUE) && !r_sent_c;
      m_axis_a_tdata       = r_buf_a[r_idx];
      m_axis_b_tdata       = r_buf_b[r_idx];
      m_axis_c_tdata       = r_acc;
      s_axis_result_tready = (r_state == WAIT);
   end

   // Operand storage carries no reset.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_buf_a[wr_addr] <= wr_a;
         r_buf_b[wr_addr] <= wr_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx     <= '0;
         r_len     <= '0;
         r_acc     <= '0;
         r_acc_out <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_tmo     <= 1'b0;
         r_cycles  <= '0;
         r_tmo_cnt <= '0;
         r_sent_a  <= 1'b0;
         r_sent_b  <= 1'b0;
         r_sent_c  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_busy && (r_cycles != 16'hFFFF)) begin
            r_cycles <= r_cycles + 16'd1;
         end
         case (r_state)
            IDLE: begin
               if (w_start_ok) begin
                  r_len    <= len;
                  r_idx    <= '0;
                  r_acc    <= '0;
                  r_err    <= 1'b0;
                  r_tmo    <= 1'b0;
                  r_cycles <= '0;
                  r_busy   <= 1'b1;
               end
            end
            ISSUE: begin
               if (w_issue_done) begin
                  r_sent_a  <= 1'b0;
                  r_sent_b  <= 1'b0;
                  r_sent_c  <= 1'b0;
                  r_tmo_cnt <= '0;
               end else begin
                  r_sent_a <= r_sent_a || w_hs_a;
                  r_sent_b <= r_sent_b || w_hs_b;
                  r_sent_c <= r_sent_c || w_hs_c;
               end
            end
            WAIT: begin
               if (w_res_hs) begin
                  r_acc <= s_axis_result_tdata;
                  if (!w_last) begin
                     r_idx <= r_idx + ADDR_W'(1);
                  end
               end else if (w_tmo_hit) begin
                  r_tmo <= 1'b1;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TW'(1);
               end
            end
            FIN: begin
               // err is published together with done, not when the timeout fires.
               r_done    <= 1'b1;
               r_acc_out <= r_acc;
               r_busy    <= 1'b0;
               r_err     <= r_tmo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mac_seq_driver.sv
// Directed bench for fp_mac_seq_driver: a MAC responder replays hand-computed results
// and checks each issued a/b/c; a run table drives the main scenarios.
module tb_fp_mac_seq_driver;

   localparam int ADDR_W  = 4;
   localparam int TIMEOUT = 64;
   localparam int LAT     = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_a;
   logic [31:0]       wr_b;
   logic              start;
   logic [ADDR_W:0]   len;
   logic              a_tvalid, b_tvalid, c_tvalid;
   logic              a_tready, b_tready, c_tready;
   logic [31:0]       a_tdata, b_tdata, c_tdata;
   logic              res_tvalid;
   logic              res_tready;
   logic [31:0]       res_tdata;
   logic              busy, done, err;
   logic [31:0]       acc_out;
   logic [15:0]       cycles;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [31:0] exp_a   [8];
   logic [31:0] exp_b   [8];
   logic [31:0] exp_c   [8];
   logic [31:0] exp_res [8];
   int          k       = 0;
   int          viol    = 0;
   int          a_stall = 0;
   bit          no_res  = 1'b0;

   fp_mac_seq_driver #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .wr_en                (wr_en),
      .wr_addr              (wr_addr),
      .wr_a                 (wr_a),
      .wr_b                 (wr_b),
      .start                (start),
      .len                  (len),
      .m_axis_a_tvalid      (a_tvalid),
      .m_axis_a_tready      (a_tready),
      .m_axis_a_tdata       (a_tdata),
      .m_axis_b_tvalid      (b_tvalid),
      .m_axis_b_tready      (b_tready),
      .m_axis_b_tdata       (b_tdata),
      .m_axis_c_tvalid      (c_tvalid),
      .m_axis_c_tready      (c_tready),
      .m_axis_c_tdata       (c_tdata),
      .s_axis_result_tvalid (res_tvalid),
      .s_axis_result_tready (res_tready),
      .s_axis_result_tdata  (res_tdata),
      .busy                 (busy),
      .done                 (done),
      .err                  (err),
      .acc_out              (acc_out),
      .cycles               (cycles)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // MAC responder: samples just after each rising edge, so its decisions apply at the next one.
   initial begin : mac_model
      bit          got_a, got_b, got_c, res_going, pending, prev_a_wait;
      logic [31:0] cap_a, cap_b, cap_c, prev_a_data;
      int          lat_cnt;
      got_a = 0; got_b = 0; got_c = 0; res_going = 0; pending = 0; prev_a_wait = 0;
      cap_a = '0; cap_b = '0; cap_c = '0; prev_a_data = '0; lat_cnt = 0;
      a_tready = 1'b1; b_tready = 1'b1; c_tready = 1'b1;
      res_tvalid = 1'b0; res_tdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            res_tvalid = 1'b0; res_going = 0; pending = 0;
            got_a = 0; got_b = 0; got_c = 0; prev_a_wait = 0;
         end else begin
            if (res_going) begin
               res_tvalid = 1'b0;
               res_going  = 0;
            end else if (pending) begin
               if (lat_cnt > 1) lat_cnt--;
               else begin
                  res_tvalid = 1'b1;
                  res_tdata  = (k >= 1 && k <= 8) ? exp_res[k-1] : 32'h0;
                  pending    = 0;
               end
            end
            if (res_tvalid && res_tready) res_going = 1;
            if (res_tready && (a_tvalid || b_tvalid || c_tvalid)) viol++;
            if ((got_a && a_tvalid) || (got_b && b_tvalid) || (got_c && c_tvalid)) viol++;
            if (a_tvalid && prev_a_wait) chk("a_tdata stable under stall", a_tdata, prev_a_data);
            if (a_tvalid && a_stall > 0) begin
               a_tready = 1'b0;
               a_stall--;
            end else begin
               a_tready = 1'b1;
            end
            prev_a_wait = a_tvalid && !a_tready;
            prev_a_data = a_tdata;
            if (a_tvalid && a_tready) begin got_a = 1; cap_a = a_tdata; end
            if (b_tvalid && b_tready) begin got_b = 1; cap_b = b_tdata; end
            if (c_tvalid && c_tready) begin got_c = 1; cap_c = c_tdata; end
            if (got_a && got_b && got_c) begin
               if (k < 8) begin
                  chk($sformatf("issue%0d a", k), cap_a, exp_a[k]);
                  chk($sformatf("issue%0d b", k), cap_b, exp_b[k]);
                  chk($sformatf("issue%0d c", k), cap_c, exp_c[k]);
               end else begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL extra issue: got issue %0d, expected at most 8", k);
               end
               k++;
               got_a = 0; got_b = 0; got_c = 0;
               pending = !no_res;
               lat_cnt = LAT;
            end
         end
      end
   end

   typedef struct {
      int          ln;
      int          stall;
      bit          nores;
      int          niss;
      logic [31:0] acc;
      bit          eerr;
      int          ewait;
      int          elat;
      int          ecyc;
      bit          poke;
   } run_t;

   task automatic wr(input int addr, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_a = a; wr_b = b;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic do_run(input int id, input run_t rr);
      int  t0, nwait, ntv, lat;
      bit  got;
      nwait = 0; ntv = 0; lat = 0; got = 0;
      a_stall = rr.stall;
      no_res  = rr.nores;
      k       = 0;
      viol    = 0;
      @(negedge clk);
      start = 1'b1;
      len   = (ADDR_W+1)'(rr.ln);
      t0    = cyc;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("run%0d busy after start", id), 32'(busy), 32'd1);
      chk($sformatf("run%0d err cleared on start", id), 32'(err), 32'd0);
      if (a_tvalid || b_tvalid || c_tvalid) ntv++;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (res_tready) nwait++;
         if (a_tvalid || b_tvalid || c_tvalid) ntv++;
         if (rr.poke && i == 3) begin
            wr_en = 1'b1; wr_addr = '0; wr_a = 32'hDEADBEEF; wr_b = 32'hDEADBEEF;
            start = 1'b1; len = (ADDR_W+1)'(1);
         end else if (rr.poke && i == 4) begin
            wr_en = 1'b0; start = 1'b0;
         end
         if (done) begin
            got = 1;
            lat = cyc - t0;
            break;
         end
      end
      wr_en = 1'b0;
      start = 1'b0;
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL run%0d done: got no pulse within 400 cycles, expected a pulse", id);
      end
      chk($sformatf("run%0d acc_out", id), acc_out, rr.acc);
      chk($sformatf("run%0d err", id), 32'(err), 32'(rr.eerr));
      chk($sformatf("run%0d busy at done", id), 32'(busy), 32'd0);
      chk($sformatf("run%0d issue count", id), 32'(k), 32'(rr.niss));
      chk($sformatf("run%0d protocol violations", id), 32'(viol), 32'd0);
      if (rr.ewait >= 0) chk($sformatf("run%0d wait cycles", id), 32'(nwait), 32'(rr.ewait));
      if (rr.elat >= 0)  chk($sformatf("run%0d start-to-done", id), 32'(lat), 32'(rr.elat));
      if (rr.ecyc >= 0)  chk($sformatf("run%0d cycles", id), 32'(cycles), 32'(rr.ecyc));
      if (rr.ln == 0)    chk($sformatf("run%0d tvalid cycles", id), 32'(ntv), 32'd0);
      @(negedge clk);
      chk($sformatf("run%0d done one cycle", id), 32'(done), 32'd0);
      chk($sformatf("run%0d busy stays low", id), 32'(busy), 32'd0);
      chk($sformatf("run%0d acc_out held", id), acc_out, rr.acc);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      run_t runs [7];
      int   cnt;
      bit   seen;

      runs[0] = '{3, 0, 1'b0, 3, 32'h40C00000, 1'b0, -1, -1, -1, 1'b0};
      runs[1] = '{3, 3, 1'b0, 3, 32'h40C00000, 1'b0, -1, -1, -1, 1'b0};
      runs[2] = '{0, 0, 1'b0, 0, 32'h00000000, 1'b0, -1,  2,  1, 1'b0};
      runs[3] = '{3, 0, 1'b1, 1, 32'h00000000, 1'b1, TIMEOUT, -1, -1, 1'b0};
      runs[4] = '{3, 0, 1'b0, 3, 32'h40C00000, 1'b0, -1, -1, -1, 1'b0};
      runs[5] = '{3, 0, 1'b0, 3, 32'h40C00000, 1'b0, -1, -1, -1, 1'b1};
      runs[6] = '{1, 0, 1'b0, 1, 32'h40000000, 1'b0, -1, -1, -1, 1'b0};

      for (int i = 0; i < 8; i++) begin
         exp_a[i] = 32'h3F800000;
         exp_b[i] = 32'h40000000;
      end
      exp_c[0] = 32'h00000000; exp_res[0] = 32'h40000000;
      exp_c[1] = 32'h40000000; exp_res[1] = 32'h40800000;
      exp_c[2] = 32'h40800000; exp_res[2] = 32'h40C00000;
      for (int i = 3; i < 8; i++) begin
         exp_c[i] = 32'h0; exp_res[i] = 32'h0;
      end

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0; start = 1'b0; len = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset acc_out", acc_out, 32'h0);
      chk("reset cycles", 32'(cycles), 32'd0);
      chk("reset tvalids", {29'd0, a_tvalid, b_tvalid, c_tvalid}, 32'd0);
      chk("reset result tready", 32'(res_tready), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) wr(i, 32'h3F800000, 32'h40000000);

      for (int r = 0; r < 7; r++) do_run(r, runs[r]);

      // start held across the FIN cycle of a len=0 run must not relaunch
      @(negedge clk);
      start = 1'b1; len = '0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("fin-start done", 32'(done), 32'd1);
      chk("fin-start busy at done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("fin-start not relaunched", 32'(busy), 32'd0);

      // reset while waiting for a result
      a_stall = 0; no_res = 1'b0; k = 0;
      @(negedge clk);
      start = 1'b1; len = (ADDR_W+1)'(3);
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (res_tready) begin seen = 1; break; end
         @(negedge clk);
      end
      chk("reset-run reached WAIT", 32'(seen), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst err", 32'(err), 32'd0);
      chk("midrst acc_out", acc_out, 32'h0);
      chk("midrst cycles", 32'(cycles), 32'd0);
      chk("midrst tvalids", {29'd0, a_tvalid, b_tvalid, c_tvalid}, 32'd0);
      chk("midrst result tready", 32'(res_tready), 32'd0);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("midrst no done pulse", 32'(cnt), 32'd0);

      wr(0, 32'h40400000, 32'h40400000);
      exp_a[0] = 32'h40400000; exp_b[0] = 32'h40400000;
      exp_c[0] = 32'h00000000; exp_res[0] = 32'h41100000;
      do_run(7, '{1, 0, 1'b0, 1, 32'h41100000, 1'b0, -1, -1, -1, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fp_mac_seq_driver.md
Name: fp_mac_seq_driver

Overview:
AXI-Stream initiator that feeds the floating-point MAC core (a*b+c, single precision) and consumes its result stream. It computes a dot product acc = sum(a[i]*b[i]) over an operand buffer loaded by the host. Each issue chains the previous MAC result back in as operand c. It sits between host/control logic and the MAC IP, driving the MAC's s_axis_a/b/c inputs and accepting its m_axis_result output.

Parameters:
ADDR_W, 4, operand buffer address width; buffer depth = 2**ADDR_W entries
TIMEOUT, 64, maximum cycles to wait for a MAC result before aborting with error

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  operand buffer write strobe, honoured only when busy=0
wr_addr  input  ADDR_W  operand buffer write address
wr_a  input  32  IEEE-754 single operand a for wr_addr
wr_b  input  32  IEEE-754 single operand b for wr_addr
start  input  1  start pulse, honoured only in IDLE
len  input  ADDR_W+1  element count, sampled on accepted start, valid range 0..2**ADDR_W
m_axis_a_tvalid  output  1  operand a valid to MAC
m_axis_a_tready  input  1  MAC ready for a
m_axis_a_tdata  output  32  operand a
m_axis_b_tvalid  output  1  operand b valid
m_axis_b_tready  input  1  MAC ready for b
m_axis_b_tdata  output  32  operand b
m_axis_c_tvalid  output  1  operand c valid
m_axis_c_tready  input  1  MAC ready for c
m_axis_c_tdata  output  32  operand c (running accumulator)
s_axis_result_tvalid  input  1  MAC result valid
s_axis_result_tready  output  1  driver ready for result
s_axis_result_tdata  input  32  MAC result
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of run
err  output  1  timeout flag; set with done, held until next accepted start
acc_out  output  32  final accumulator, valid from done until next accepted start
cycles  output  16  clk cycles from accepted start to done, saturating at 16'hFFFF

Behaviour:
- Reset: state=IDLE. All tvalid=0, s_axis_result_tready=0, busy=0, done=0, err=0, acc_out=0, cycles=0, idx=0, internal acc=32'h00000000. Operand buffer contents are not reset.
- Reset asserted mid-run aborts immediately to the reset state. No done pulse is generated.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - wr_en writes {wr_a,wr_b} to buffer[wr_addr].
  - start captures len, clears idx/acc/err/cycles and sets busy.
  - If len==0, go to FIN; otherwise go to ISSUE.
- ISSUE:
  - Assert a/b/c tvalid, with a=buf[idx].a, b=buf[idx].b, c=acc.
  - Each channel completes independently on tvalid&tready, after which that channel's tvalid drops. A per-channel sent flag tracks completion.
  - Data stays stable while tvalid=1 and tready=0.
  - When all three channels have completed (same cycle or different cycles), clear the sent flags, clear the timeout counter and go to WAIT.
- WAIT:
  - s_axis_result_tready=1.
  - On result handshake: acc<=tdata. If idx==len-1, go to FIN; else idx<=idx+1 and go to ISSUE.
  - If TIMEOUT cycles elapse with no result, set err and go to FIN. acc keeps its last value.
- FIN:
  - For one cycle: done=1, acc_out<=acc, busy<=0. Next state is IDLE.
  - A start arriving in FIN is ignored.
- Timing and counters:
  - cycles increments every cycle while busy, saturating at 16'hFFFF.
  - start is ignored outside IDLE. wr_en is ignored while busy.
  - idx wrap cannot occur, because len is at most 2**ADDR_W.
  - No tvalid is asserted outside ISSUE. s_axis_result_tready is 0 outside WAIT.
  - A result tvalid arriving outside WAIT is not accepted. It is left pending, since tready=0.
- No floating-point arithmetic is performed inside this block. Data is passed through bit-exactly.

Test Plan:
- Basic chain: load buf[0..2]={3F800000,40000000}; start len=3; bench MAC model with 5-cycle latency and tready=1 -> three issues with c = 00000000, 40000000, 40800000; acc_out=40C00000 (6.0); done pulses once; err=0.
- Backpressure: same load; a_tready held low 3 cycles while b/c are accepted at once -> a_tdata stays stable, b/c tvalid drop after their handshake, WAIT entered only after a completes; final acc_out=40C00000.
- len=0: start -> done asserted 2 cycles after start; acc_out=00000000; no tvalid ever asserted; cycles=1.
- Timeout: model never returns a result, TIMEOUT=64 -> err=1 and done pulse 64 cycles after entering WAIT; acc_out=00000000; err clears on the next start.
- Ignored inputs: start and wr_en to buf[0] pulsed mid-run -> run completes unchanged; a subsequent run reads the original buf[0].
- Reset mid-WAIT: rst for 1 cycle -> next cycle all outputs at reset values, no done pulse; a fresh start len=1 with buf[0]={40400000,40400000} -> acc_out=41100000 (9.0).
